// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and types for the multi-port register file.
//   REGFILE_WIDTH / REGFILE_DEPTH : default data width and register count
//   reg_addr_t / reg_data_t       : address and data types at the default size
//   bit_to_cnt()                  : widens a 1-bit event into a busy-count delta
// Optional build macro used by the top: REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int REGFILE_WIDTH = 32;
    localparam int REGFILE_DEPTH = 32;
    localparam int REGFILE_AW    = $clog2(REGFILE_DEPTH);

    typedef logic [REGFILE_AW-1:0]    reg_addr_t;
    typedef logic [REGFILE_WIDTH-1:0] reg_data_t;

    // Busy count is at most REGFILE_AW+1 bits wide for the default depth.
    function automatic logic [REGFILE_AW:0] bit_to_cnt(input logic b);
        return {{REGFILE_AW{1'b0}}, b};
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits plus a live count of busy registers.
// Ports:
//   clk, reset           : rising-edge clock, async active-high reset
//   wr_en0/1, wr_addr0/1 : write ports; a write clears the target's busy bit
//   issue_en, issue_addr : marks a destination busy; beats a same-edge write
//   rd_addr_a/b          : lookup addresses
//   busy_a/b             : combinational busy bit of rd_addr_a/b
//   busy_count           : registered number of busy registers
module regfile_scoreboard #(
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en0,
    input  logic [AW-1:0] wr_addr0,
    input  logic          wr_en1,
    input  logic [AW-1:0] wr_addr1,
    input  logic          issue_en,
    input  logic [AW-1:0] issue_addr,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic          busy_a,
    output logic          busy_b,
    output logic [AW:0]   busy_count
);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [AW:0]      count_q, count_d;
    logic             inc, dec0, dec1;

    always_comb begin
        busy_d = busy_q;
        if (wr_en0)   busy_d[wr_addr0]   = 1'b0;
        if (wr_en1)   busy_d[wr_addr1]   = 1'b0;
        if (issue_en) busy_d[issue_addr] = 1'b1;
    end

    // Count deltas mirror the bit transitions: a clear only counts when the
    // bit was set and no issue re-sets it, and two writes to the same busy
    // register clear it once.
    always_comb begin
        inc  = issue_en && !busy_q[issue_addr];
        dec0 = wr_en0 && busy_q[wr_addr0]
               && !(issue_en && (issue_addr == wr_addr0));
        dec1 = wr_en1 && busy_q[wr_addr1]
               && !(issue_en && (issue_addr == wr_addr1))
               && !(wr_en0 && (wr_addr0 == wr_addr1));
        count_d = count_q + {{AW{1'b0}}, inc}
                          - {{AW{1'b0}}, dec0}
                          - {{AW{1'b0}}, dec1};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_a     = busy_q[rd_addr_a];
    assign busy_b     = busy_q[rd_addr_b];
    assign busy_count = count_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: two-write, two-read register file with a busy scoreboard.
// Ports:
//   clk, reset                      : rising-edge clock, async active-high reset
//   rd_addr_a/b -> rd_data_a/b      : combinational reads
//   wr_en0/wr_addr0/wr_data0        : write port 0
//   wr_en1/wr_addr1/wr_data1        : write port 1, wins on an address collision
//   issue_en/issue_addr             : marks a destination register busy
//   busy_a/b, busy_count            : scoreboard lookups and busy total
// Build macro REGFILE_BYPASS_EN: when defined, a read that matches an enabled
// write in the same cycle returns the write data (port 1 first); otherwise
// reads see the array value and new data appears after the write edge.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int WIDTH = REGFILE_WIDTH,
    parameter  int DEPTH = REGFILE_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             wr_en0,
    input  logic [AW-1:0]    wr_addr0,
    input  logic [WIDTH-1:0] wr_data0,
    input  logic             wr_en1,
    input  logic [AW-1:0]    wr_addr1,
    input  logic [WIDTH-1:0] wr_data1,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_addr,
    output logic             busy_a,
    output logic             busy_b,
    output logic [AW:0]      busy_count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Port 1 is applied last so it overrides port 0 on the same address.
    always_comb begin
        mem_d = mem_q;
        if (wr_en0) mem_d[wr_addr0] = wr_data0;
        if (wr_en1) mem_d[wr_addr1] = wr_data1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rd_data_a = mem_q[rd_addr_a];
        rd_data_b = mem_q[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        // Held reset must still read as zero, so the bypass is gated off.
        if (!reset) begin
            if (wr_en1 && (wr_addr1 == rd_addr_a))      rd_data_a = wr_data1;
            else if (wr_en0 && (wr_addr0 == rd_addr_a)) rd_data_a = wr_data0;
            if (wr_en1 && (wr_addr1 == rd_addr_b))      rd_data_b = wr_data1;
            else if (wr_en0 && (wr_addr0 == rd_addr_b)) rd_data_b = wr_data0;
        end
`endif
    end

    regfile_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .wr_en0     (wr_en0),
        .wr_addr0   (wr_addr0),
        .wr_en1     (wr_en1),
        .wr_addr1   (wr_addr1),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .busy_a     (busy_a),
        .busy_b     (busy_b),
        .busy_count (busy_count)
    );

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    reg_addr_t   rd_addr_a, rd_addr_b, wr_addr0, wr_addr1, issue_addr;
    reg_data_t   rd_data_a, rd_data_b, wr_data0, wr_data1;
    logic        wr_en0, wr_en1, issue_en, busy_a, busy_b;
    logic [5:0]  busy_count;

    int total = 0;
    int bad   = 0;

    regfile_mp dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr_a  (rd_addr_a),
        .rd_data_a  (rd_data_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_b  (rd_data_b),
        .wr_en0     (wr_en0),
        .wr_addr0   (wr_addr0),
        .wr_data0   (wr_data0),
        .wr_en1     (wr_en1),
        .wr_addr1   (wr_addr1),
        .wr_data1   (wr_data1),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .busy_a     (busy_a),
        .busy_b     (busy_b),
        .busy_count (busy_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic      we0;
        reg_addr_t wa0;
        reg_data_t wd0;
        logic      we1;
        reg_addr_t wa1;
        reg_data_t wd1;
        logic      ie;
        reg_addr_t ia;
        reg_addr_t ra;
        reg_addr_t rb;
        reg_data_t exp_a;
        reg_data_t exp_b;
        logic      exp_busy_a;
        logic      exp_busy_b;
        int        exp_count;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_en0   = 1'b0; wr_addr0 = '0; wr_data0 = '0;
        wr_en1   = 1'b0; wr_addr1 = '0; wr_data1 = '0;
        issue_en = 1'b0; issue_addr = '0;
    endtask

    task automatic apply_vec(input int n);
        @(negedge clk);
        wr_en0 = vecs[n].we0; wr_addr0 = vecs[n].wa0; wr_data0 = vecs[n].wd0;
        wr_en1 = vecs[n].we1; wr_addr1 = vecs[n].wa1; wr_data1 = vecs[n].wd1;
        issue_en = vecs[n].ie; issue_addr = vecs[n].ia;
        rd_addr_a = vecs[n].ra; rd_addr_b = vecs[n].rb;
        @(posedge clk);
        #1 idle_inputs();
        #1;
        chk($sformatf("v%0d rd_a", n), rd_data_a, vecs[n].exp_a);
        chk($sformatf("v%0d rd_b", n), rd_data_b, vecs[n].exp_b);
        chk($sformatf("v%0d busy_a", n), {31'd0, busy_a}, {31'd0, vecs[n].exp_busy_a});
        chk($sformatf("v%0d busy_b", n), {31'd0, busy_b}, {31'd0, vecs[n].exp_busy_b});
        chk($sformatf("v%0d count", n), {26'd0, busy_count}, vecs[n].exp_count);
    endtask

    initial begin
        //            we0 wa0 wd0     we1 wa1 wd1  ie ia  ra rb  exp_a exp_b ba bb cnt
        vecs[0]  = '{1, 5, 11,     1, 5, 22,  0, 0,  5, 0,  22,   69,   0, 0, 0};
        vecs[1]  = '{1, 3, 7,      1, 4, 8,   0, 0,  3, 4,  7,    8,    0, 0, 0};
        vecs[2]  = '{0, 0, 0,      0, 0, 0,   1, 2,  2, 3,  0,    7,    1, 0, 1};
        vecs[3]  = '{0, 0, 0,      0, 0, 0,   1, 3,  2, 3,  0,    7,    1, 1, 2};
        vecs[4]  = '{0, 0, 0,      0, 0, 0,   1, 4,  4, 3,  8,    7,    1, 1, 3};
        vecs[5]  = '{1, 2, 100,    1, 3, 200, 0, 0,  2, 3,  100,  200,  0, 0, 1};
        vecs[6]  = '{1, 6, 66,     0, 0, 0,   1, 6,  6, 4,  66,   8,    1, 1, 2};
        vecs[7]  = '{0, 0, 0,      1, 6, 77,  1, 6,  6, 4,  77,   8,    1, 1, 2};
        vecs[8]  = '{1, 4, 9,      1, 4, 10,  0, 0,  4, 6,  10,   77,   0, 1, 1};
        vecs[9]  = '{0, 0, 0,      0, 0, 0,   1, 6,  6, 0,  77,   69,   1, 0, 1};
        vecs[10] = '{0, 6, 'hdead, 1, 7, 5,   0, 0,  6, 7,  77,   5,    1, 0, 1};
        vecs[11] = '{0, 0, 0,      1, 6, 1,   0, 0,  6, 7,  1,    5,    0, 0, 0};

        idle_inputs();
        rd_addr_a = '0; rd_addr_b = '0;
        reset = 1'b1;

        // Reset held: writes are discarded.
        #1;
        chk("rst rd_a", rd_data_a, 32'd0);
        chk("rst count", {26'd0, busy_count}, 32'd0);
        @(negedge clk);
        wr_en0 = 1'b1; wr_addr0 = 5'd0; wr_data0 = 32'd69;
        @(posedge clk);
        #1;
        chk("rst write dropped", rd_data_a, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 idle_inputs();
        #1;
        chk("post-rst write r0", rd_data_a, 32'd69);

        for (int i = 0; i < 12; i++) apply_vec(i);

        // Same-cycle read of a register being written.
        @(negedge clk);
        wr_en0 = 1'b1; wr_addr0 = 5'd1; wr_data0 = 32'd35;
        rd_addr_a = 5'd1;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass pre-edge", rd_data_a, 32'd35);
`else
        chk("no-bypass pre-edge", rd_data_a, 32'd0);
`endif
        @(posedge clk);
        #1 idle_inputs();
        #1;
        chk("r1 after edge", rd_data_a, 32'd35);

        // Fill the scoreboard.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            issue_en = 1'b1; issue_addr = reg_addr_t'(i);
            @(posedge clk);
            #1 idle_inputs();
            if (i == 15) begin
                #1 chk("count half", {26'd0, busy_count}, 32'd16);
            end
        end
        #1;
        chk("count full", {26'd0, busy_count}, 32'd32);
        @(negedge clk);
        issue_en = 1'b1; issue_addr = 5'd0;
        @(posedge clk);
        #1 idle_inputs();
        #1;
        chk("count reissue", {26'd0, busy_count}, 32'd32);
        rd_addr_a = 5'd6;
        #1;
        chk("busy_a full", {31'd0, busy_a}, 32'd1);

        // Asynchronous reset between edges.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async rst count", {26'd0, busy_count}, 32'd0);
        chk("async rst busy_a", {31'd0, busy_a}, 32'd0);
        chk("async rst rd_a", rd_data_a, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rd_addr_b = 5'd0;
        #1;
        chk("after rst r0", rd_data_b, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
